// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding constants and types for the branch encoder.
package rv_isa_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned F3_W  = 3;

  localparam logic [6:0]      OPC_BRANCH = 7'b1100011;
  localparam logic [XLEN-1:0] NOP_INS    = 32'h0000_0013;

  typedef enum logic [F3_W-1:0] {
    F3_BEQ  = 3'd0,
    F3_BNE  = 3'd1,
    F3_BLT  = 3'd4,
    F3_BGE  = 3'd5,
    F3_BLTU = 3'd6,
    F3_BGEU = 3'd7
  } br_funct3_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_FUNCT3   = 2'd3
  } br_err_e;

  // Stage-1 payload: byte offset plus the register/condition fields.
  typedef struct packed {
    logic [F3_W-1:0]  funct3;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [XLEN-1:0]  off;
  } br_stage1_t;

  // True when funct3 names one of the six defined branch conditions.
  function automatic logic f3_is_branch(input logic [F3_W-1:0] f3);
    logic legal;
    legal = 1'b0;
    case (f3)
      F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/b_packer.sv
// Packs branch fields into the B-format word; field order matches the immediate splitter.
module b_packer
  import rv_isa_pkg::*;
(
  input  logic [F3_W-1:0]  i_funct3,
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rs2,
  input  logic [12:1]      i_imm,
  output logic [XLEN-1:0]  o_ins
);

  assign o_ins = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                  i_imm[4:1], i_imm[11], OPC_BRANCH};

endmodule

// File: rtl/b_type_encoder.sv
// Two-stage valid/ready encoder turning a branch description into an RV32I B-type word.
module b_type_encoder
  import rv_isa_pkg::*;
#(
  parameter int unsigned IALIGN    = 4,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [F3_W-1:0]      in_funct3,
  input  logic [REG_W-1:0]     in_rs1,
  input  logic [REG_W-1:0]     in_rs2,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [XLEN-1:0]      in_target,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_ins,
  output logic                 out_err,
  output logic [1:0]           out_err_code,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned       ALIGN_MASK = IALIGN - 1;
  localparam logic signed [31:0] OFF_MIN   = -32'sd4096;
  localparam logic signed [31:0] OFF_MAX   = 32'sd4094;

  logic                 r_v1;
  br_stage1_t           r_s1;
  logic                 r_v2;
  logic [XLEN-1:0]      r_ins;
  logic                 r_err;
  br_err_e              r_code;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic                 w_adv2;
  logic                 w_acc1;
  logic                 w_xfer_out;
  br_err_e              w_code;
  logic [XLEN-1:0]      w_packed;
  logic [XLEN-1:0]      w_ins;

  // Readiness depends only on stage state and out_ready, never on in_valid.
  assign w_adv2     = !r_v2 || out_ready;
  assign in_ready   = !r_v1 || w_adv2;
  assign w_acc1     = in_valid && in_ready;
  assign w_xfer_out = r_v2 && out_ready;

  // Stage 1: capture fields and the modulo-2^32 byte offset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_s1 <= '0;
    end else begin
      if (in_ready) r_v1 <= in_valid;
      if (w_acc1) begin
        r_s1.funct3 <= in_funct3;
        r_s1.rs1    <= in_rs1;
        r_s1.rs2    <= in_rs2;
        r_s1.off    <= in_target - in_pc;
      end
    end
  end

  // Legality checks in priority order: funct3, alignment, reach.
  always_comb begin
    w_code = ERR_NONE;
    if (!f3_is_branch(r_s1.funct3)) begin
      w_code = ERR_FUNCT3;
    end else if ((r_s1.off & 32'(ALIGN_MASK)) != '0) begin
      w_code = ERR_MISALIGN;
    end else if (($signed(r_s1.off) < OFF_MIN) || ($signed(r_s1.off) > OFF_MAX)) begin
      w_code = ERR_RANGE;
    end
  end

  b_packer u_packer (
    .i_funct3 (r_s1.funct3),
    .i_rs1    (r_s1.rs1),
    .i_rs2    (r_s1.rs2),
    .i_imm    (r_s1.off[12:1]),
    .o_ins    (w_packed)
  );

  assign w_ins = (w_code == ERR_NONE) ? w_packed : NOP_INS;

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_ins  <= '0;
      r_err  <= 1'b0;
      r_code <= ERR_NONE;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_ins  <= w_ins;
        r_err  <= (w_code != ERR_NONE);
        r_code <= w_code;
      end
    end
  end

  // Saturating count of errored words actually handed to the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (w_xfer_out && r_err && (r_err_count != '1)) begin
      r_err_count <= r_err_count + ERR_CNT_W'(1);
    end
  end

  assign out_valid    = r_v2;
  assign out_ins      = r_ins;
  assign out_err      = r_err;
  assign out_err_code = r_code;
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_b_type_encoder.sv
// Scoreboard bench driving an IALIGN=4 and an IALIGN=2 encoder in lockstep.
module tb_b_type_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_pc;
  logic [31:0] in_target;
  logic        out_ready;

  logic        in_ready4, out_valid4, out_err4;
  logic [31:0] out_ins4;
  logic [1:0]  out_code4;
  logic [7:0]  err_count4;
  logic        in_ready2, out_valid2, out_err2;
  logic [31:0] out_ins2;
  logic [1:0]  out_code2;
  logic [7:0]  err_count2;

  always #5 clk = ~clk;

  b_type_encoder #(.IALIGN(4), .ERR_CNT_W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc),
    .in_target(in_target), .out_valid(out_valid4), .out_ready(out_ready),
    .out_ins(out_ins4), .out_err(out_err4), .out_err_code(out_code4),
    .err_count(err_count4)
  );

  b_type_encoder #(.IALIGN(2), .ERR_CNT_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc),
    .in_target(in_target), .out_valid(out_valid2), .out_ready(out_ready),
    .out_ins(out_ins2), .out_err(out_err2), .out_err_code(out_code2),
    .err_count(err_count2)
  );

  typedef struct packed {
    logic [31:0] ins4;
    logic        err4;
    logic [1:0]  code4;
    logic [31:0] ins2;
    logic        err2;
    logic [1:0]  code2;
    logic        rt;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] off;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_deliv  = 0;
  int   exp_cnt4 = 0;
  int   exp_cnt2 = 0;
  int   snap;
  logic rand_ready = 1'b0;
  logic [2:0] legal_f3 [6];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference encoding built field by field with shifts.
  function automatic void calc(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] off, input int unsigned ialign,
                               output logic [31:0] ins, output logic [1:0] code);
    int so;
    so = $signed(off);
    if (f3 == 3'd2 || f3 == 3'd3)                code = 2'd3;
    else if ((off & 32'(ialign - 1)) != 32'd0)   code = 2'd1;
    else if (so < -4096 || so > 4094)            code = 2'd2;
    else                                         code = 2'd0;
    if (code != 2'd0) begin
      ins = 32'h0000_0013;
    end else begin
      ins = 32'h0000_0063;
      ins |= 32'(off[11]) << 7;
      ins |= 32'(off[4:1]) << 8;
      ins |= 32'(f3) << 12;
      ins |= 32'(rs1) << 15;
      ins |= 32'(rs2) << 20;
      ins |= 32'(off[10:5]) << 25;
      ins |= 32'(off[12]) << 31;
    end
  endfunction

  task automatic present(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] pc, input logic [31:0] tgt);
    in_valid  = 1'b1;
    in_funct3 = f3;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_pc     = pc;
    in_target = tgt;
  endtask

  task automatic send(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] pc, input logic [31:0] tgt,
                      input logic use_lit, input logic [31:0] lit);
    exp_t        e;
    logic        ok;
    logic [31:0] off, i4, i2;
    logic [1:0]  c4, c2;
    off = tgt - pc;
    calc(f3, rs1, rs2, off, 4, i4, c4);
    calc(f3, rs1, rs2, off, 2, i2, c2);
    e.ins4  = use_lit ? lit : i4;
    e.code4 = c4;
    e.err4  = (c4 != 2'd0);
    e.ins2  = i2;
    e.code2 = c2;
    e.err2  = (c2 != 2'd0);
    e.rt    = (c4 == 2'd0);
    e.f3    = f3;
    e.rs1   = rs1;
    e.rs2   = rs2;
    e.off   = off;
    present(f3, rs1, rs2, pc, tgt);
    ok = 1'b0;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      if (in_ready4) begin
        sb.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    check("accept", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
    #1;
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    legal_f3  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    rst_n     = 1'b0;
    out_ready = 1'b1;
    present(3'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    in_valid  = 1'b0;

    fork
      begin
        exp_t       me;
        logic [12:0] imm;
        forever begin
          @(negedge clk);
          if (rst_n && out_valid4) begin
            if (sb.size() == 0) begin
              check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
              me = sb[0];
              check("ins4",   out_ins4,          me.ins4);
              check("err4",   32'(out_err4),     32'(me.err4));
              check("code4",  32'(out_code4),    32'(me.code4));
              check("valid2", 32'(out_valid2),   32'd1);
              check("ins2",   out_ins2,          me.ins2);
              check("err2",   32'(out_err2),     32'(me.err2));
              check("code2",  32'(out_code2),    32'(me.code2));
              if (out_ready) begin
                check("cnt4", 32'(err_count4), 32'(exp_cnt4));
                check("cnt2", 32'(err_count2), 32'(exp_cnt2));
                if (me.rt) begin
                  imm = {out_ins4[31], out_ins4[7], out_ins4[30:25], out_ins4[11:8], 1'b0};
                  check("rt_opc", 32'(out_ins4[6:0]),   32'h63);
                  check("rt_f3",  32'(out_ins4[14:12]), 32'(me.f3));
                  check("rt_rs1", 32'(out_ins4[19:15]), 32'(me.rs1));
                  check("rt_rs2", 32'(out_ins4[24:20]), 32'(me.rs2));
                  check("rt_off", {{19{imm[12]}}, imm}, me.off);
                end
                if (me.err4 && exp_cnt4 != 255) exp_cnt4++;
                if (me.err2 && exp_cnt2 != 255) exp_cnt2++;
                void'(sb.pop_front());
                n_deliv++;
              end
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready4),  32'd1);
    check("rst_out_valid", 32'(out_valid4), 32'd0);
    check("rst_out_ins",   out_ins4,        32'd0);
    check("rst_out_err",   32'(out_err4),   32'd0);
    check("rst_code",      32'(out_code4),  32'd0);
    check("rst_cnt",       32'(err_count4), 32'd0);
    check("rst_valid2",    32'(out_valid2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed encodings and limits
    send(3'd0, 5'd1,  5'd2,  32'h100,       32'h108,        1'b1, 32'h0020_8463);
    send(3'd1, 5'd5,  5'd6,  32'h200,       32'h1FC,        1'b1, 32'hFE62_9EE3);
    send(3'd0, 5'd3,  5'd4,  32'h0,         32'hFFE,        1'b0, 32'd0);
    send(3'd0, 5'd3,  5'd4,  32'h0,         32'h1000,       1'b1, 32'h0000_0013);
    send(3'd5, 5'd7,  5'd8,  32'h1000,      32'h0,          1'b0, 32'd0);
    send(3'd2, 5'd1,  5'd1,  32'h100,       32'h108,        1'b1, 32'h0000_0013);
    send(3'd3, 5'd1,  5'd1,  32'h100,       32'h106,        1'b0, 32'd0);
    send(3'd4, 5'd9,  5'd10, 32'h100,       32'h106,        1'b0, 32'd0);
    send(3'd6, 5'd11, 5'd12, 32'hFFFF_FFFC, 32'h4,          1'b0, 32'd0);
    send(3'd7, 5'd31, 5'd31, 32'h40,        32'h40,         1'b0, 32'd0);
    send(3'd1, 5'd2,  5'd3,  32'h2000,      32'h2000 - 32'd4100, 1'b0, 32'd0);
    send(3'd1, 5'd2,  5'd3,  32'h3000,      32'h3000 + 32'd4092, 1'b0, 32'd0);
    send(3'd5, 5'd4,  5'd4,  32'h3000,      32'h3000 - 32'd4098, 1'b0, 32'd0);
    drain();

    // Backpressure: two accepts fill the pipe, then release with no bubble
    out_ready = 1'b0;
    send(3'd0, 5'd1, 5'd1, 32'h0, 32'h10,   1'b0, 32'd0);
    send(3'd1, 5'd2, 5'd2, 32'h0, 32'h1000, 1'b0, 32'd0);
    present(3'd4, 5'd3, 5'd3, 32'h0, 32'h20);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready",  32'(in_ready4),  32'd0);
      check("bp_out_valid", 32'(out_valid4), 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    snap = n_deliv;
    send(3'd4, 5'd3, 5'd3, 32'h0, 32'h20, 1'b0, 32'd0);
    send(3'd5, 5'd4, 5'd4, 32'h0, 32'h1C, 1'b0, 32'd0);
    send(3'd6, 5'd5, 5'd5, 32'h0, 32'h30, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("bp_deliv", 32'(n_deliv - snap), 32'd5);
    drain();

    // Reset with both stages full
    out_ready = 1'b0;
    send(3'd3, 5'd1, 5'd1, 32'h0, 32'h8,  1'b0, 32'd0);
    send(3'd0, 5'd2, 5'd2, 32'h0, 32'h10, 1'b0, 32'd0);
    check("pre_rst_cnt4", 32'(err_count4), 32'(exp_cnt4));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",    32'(out_valid4), 32'd0);
    check("mid_rst_cnt",      32'(err_count4), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready4),  32'd1);
    check("mid_rst_ins",      out_ins4,        32'd0);
    sb.delete();
    exp_cnt4  = 0;
    exp_cnt2  = 0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(out_valid4), 32'd0);
    end
    @(posedge clk);
    #1;

    // Counter saturation
    for (int i = 0; i < 300; i++) send(3'd2, 5'(i), 5'(i), 32'h0, 32'h8, 1'b0, 32'd0);
    drain();
    check("sat_cnt4", 32'(err_count4), 32'd255);
    check("sat_cnt2", 32'(err_count2), 32'd255);

    // Random legal round-trip with random consumer stalls
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] pc;
      logic [2:0]  idx;
      int          o;
      pc  = $urandom() & 32'hFFFF_FFFC;
      o   = int'($urandom_range(0, 2047)) * 4 - 4096;
      idx = 3'($urandom_range(0, 5));
      send(legal_f3[idx], 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           pc, pc + 32'(o), 1'b0, 32'd0);
    end
    rand_ready = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
